// File: rtl/regfile_sb_pkg.sv
// Shared core constants and the register-index type for the register file and scoreboard.
package regfile_sb_pkg;
   localparam int CPU_WIDTH = 64;
   localparam int REG_ADDRW = 5;
   localparam int CNT_WIDTH = 2;
   localparam int NUM_REGS  = 1 << REG_ADDRW;

   typedef logic [REG_ADDRW-1:0] reg_idx_t;
endpackage

// File: rtl/regfile_sb_cnt.sv
// One in-flight write counter for a single architectural register.
// eff is the count after this cycle's retire/cancel releases, so a register
// whose last producer writes back this cycle is already seen as not busy.
module rf_sb_cnt
   import regfile_sb_pkg::*;
#(
   parameter int CW = CNT_WIDTH
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc,
   input  logic          dec_wb,
   input  logic          dec_cnl,
   output logic [CW-1:0] eff,
   output logic          busy,
   output logic          full
);
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

   logic [CW-1:0] cnt;
   logic [CW:0]   dec_sum;
   logic [CW:0]   eff_wide;

   // Releases are applied before the issue increment; the extra MSB flags underflow.
   always_comb begin
      dec_sum  = {{CW{1'b0}}, dec_wb} + {{CW{1'b0}}, dec_cnl};
      eff_wide = {1'b0, cnt} - dec_sum;
      eff      = eff_wide[CW-1:0];
      busy     = (eff != '0);
      full     = (eff == CNT_MAX);
   end

   // Counter register: next = cnt + inc - retire - cancel.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else begin
         cnt <= eff + {{(CW-1){1'b0}}, inc};
      end
   end

   // A retire or cancel must always match an outstanding write.
   a_no_underflow: assert property (@(posedge clk) disable iff (rst) !eff_wide[CW]);
   // Issue logic must never push a full counter past its maximum.
   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(inc && full));
endmodule

// File: rtl/regfile_sb.sv
// Integer register file with write-back bypass and an issue scoreboard that
// stalls RAW/WAW hazards until the producer writes back or is squashed.
//
// Issue handshake: o_iss_ready is a combinational function of the source/dest
// fields and the scoreboard only (never of i_iss_valid); an instruction issues
// on a rising edge where i_iss_valid && o_iss_ready, and only then may its
// destination counter increment.
module regfile_sb
   import regfile_sb_pkg::*;
(
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_wbu_rdwen,
   input  logic [REG_ADDRW-1:0] i_wbu_rdid,
   input  logic [CPU_WIDTH-1:0] i_wbu_rd,
   input  logic                 i_iss_valid,
   output logic                 o_iss_ready,
   input  logic [REG_ADDRW-1:0] i_iss_rs1id,
   input  logic                 i_iss_rs1en,
   input  logic [REG_ADDRW-1:0] i_iss_rs2id,
   input  logic                 i_iss_rs2en,
   input  logic [REG_ADDRW-1:0] i_iss_rdid,
   input  logic                 i_iss_rdwen,
   output logic [CPU_WIDTH-1:0] o_rs1,
   output logic [CPU_WIDTH-1:0] o_rs2,
   input  logic                 i_cnl_valid,
   input  logic [REG_ADDRW-1:0] i_cnl_rdid
);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   logic [CPU_WIDTH-1:0] regs [NUM_REGS];
   logic [CNT_WIDTH-1:0] eff_v [NUM_REGS];
   logic [NUM_REGS-1:0]  busy_v;
   logic [NUM_REGS-1:0]  full_v;
   logic                 wb_en;
   logic                 iss_fire;

   assign wb_en    = i_wbu_rdwen && (i_wbu_rdid != '0);
   assign iss_fire = i_iss_valid && o_iss_ready;

   // x0 has no counter: never busy, never full.
   assign eff_v[0]  = '0;
   assign busy_v[0] = 1'b0;
   assign full_v[0] = 1'b0;

   for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
      rf_sb_cnt #(.CW(CNT_WIDTH)) u_cnt (
         .clk     (i_clk),
         .rst     (i_rst),
         .inc     (iss_fire && i_iss_rdwen && (i_iss_rdid == reg_idx_t'(g))),
         .dec_wb  (i_wbu_rdwen && (i_wbu_rdid == reg_idx_t'(g))),
         .dec_cnl (i_cnl_valid && (i_cnl_rdid == reg_idx_t'(g))),
         .eff     (eff_v[g]),
         .busy    (busy_v[g]),
         .full    (full_v[g])
      );
   end

   // Register array: writes to x0 are dropped, reset clears every entry.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wb_en) begin
         regs[i_wbu_rdid] <= i_wbu_rd;
      end
   end

   // Read ports: x0 reads zero, a same-cycle write-back is forwarded.
   always_comb begin
      o_rs1 = '0;
      o_rs2 = '0;
      if (i_iss_rs1id != '0) begin
         o_rs1 = (wb_en && (i_wbu_rdid == i_iss_rs1id)) ? i_wbu_rd : regs[i_iss_rs1id];
      end
      if (i_iss_rs2id != '0) begin
         o_rs2 = (wb_en && (i_wbu_rdid == i_iss_rs2id)) ? i_wbu_rd : regs[i_iss_rs2id];
      end
   end

   // Issue permission: stall on busy sources (RAW) or a saturated destination (WAW).
   always_comb begin
      o_iss_ready = !(i_iss_rs1en && busy_v[i_iss_rs1id]) &&
                    !(i_iss_rs2en && busy_v[i_iss_rs2id]) &&
                    !(i_iss_rdwen && full_v[i_iss_rdid]);
   end

   // An issued destination write always finds room in its counter.
   a_fire_has_room: assert property (@(posedge i_clk) disable iff (i_rst)
      !(iss_fire && i_iss_rdwen && (i_iss_rdid != '0) && (eff_v[i_iss_rdid] == CNT_MAX)));
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: hazards, bypass, x0, saturation, cancel, reset.
module tb_regfile_sb;
   import regfile_sb_pkg::*;

   logic                 clk;
   logic                 rst;
   logic                 wbu_rdwen;
   logic [REG_ADDRW-1:0] wbu_rdid;
   logic [CPU_WIDTH-1:0] wbu_rd;
   logic                 iss_valid;
   logic                 iss_ready;
   logic [REG_ADDRW-1:0] iss_rs1id;
   logic                 iss_rs1en;
   logic [REG_ADDRW-1:0] iss_rs2id;
   logic                 iss_rs2en;
   logic [REG_ADDRW-1:0] iss_rdid;
   logic                 iss_rdwen;
   logic [CPU_WIDTH-1:0] rs1;
   logic [CPU_WIDTH-1:0] rs2;
   logic                 cnl_valid;
   logic [REG_ADDRW-1:0] cnl_rdid;

   int n_cmp = 0;
   int n_err = 0;

   regfile_sb dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_wbu_rdwen (wbu_rdwen),
      .i_wbu_rdid  (wbu_rdid),
      .i_wbu_rd    (wbu_rd),
      .i_iss_valid (iss_valid),
      .o_iss_ready (iss_ready),
      .i_iss_rs1id (iss_rs1id),
      .i_iss_rs1en (iss_rs1en),
      .i_iss_rs2id (iss_rs2id),
      .i_iss_rs2en (iss_rs2en),
      .i_iss_rdid  (iss_rdid),
      .i_iss_rdwen (iss_rdwen),
      .o_rs1       (rs1),
      .o_rs2       (rs2),
      .i_cnl_valid (cnl_valid),
      .i_cnl_rdid  (cnl_rdid)
   );

   // Clock and watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [CPU_WIDTH-1:0] act,
                        input logic [CPU_WIDTH-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   // Advance one edge, then give inputs time away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle();
      wbu_rdwen = 1'b0; wbu_rdid = '0; wbu_rd = '0;
      iss_valid = 1'b0; iss_rdwen = 1'b0; iss_rdid = '0;
      iss_rs1id = '0; iss_rs1en = 1'b0; iss_rs2id = '0; iss_rs2en = 1'b0;
      cnl_valid = 1'b0; cnl_rdid = '0;
   endtask

   task automatic issue(input logic valid, input logic [REG_ADDRW-1:0] rd, input logic rdwen,
                        input logic [REG_ADDRW-1:0] r1, input logic r1en,
                        input logic [REG_ADDRW-1:0] r2, input logic r2en);
      iss_valid = valid; iss_rdid = rd; iss_rdwen = rdwen;
      iss_rs1id = r1; iss_rs1en = r1en; iss_rs2id = r2; iss_rs2en = r2en;
   endtask

   task automatic wb(input logic en, input logic [REG_ADDRW-1:0] rd,
                     input logic [CPU_WIDTH-1:0] data);
      wbu_rdwen = en; wbu_rdid = rd; wbu_rd = data;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      issue(1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b1);
      settle();
      check("rst_rs1", rs1, 64'd0);
      check("rst_rs2", rs2, 64'd0);
      check("rst_ready", {63'd0, iss_ready}, 64'd1);

      // RAW on x3 with bypass release
      issue(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      settle();
      check("x3_prod_ready", {63'd0, iss_ready}, 64'd1);
      tick();
      issue(1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0);
      settle();
      check("x3_raw_stall0", {63'd0, iss_ready}, 64'd0);
      tick();
      check("x3_raw_stall1", {63'd0, iss_ready}, 64'd0);
      tick();
      wb(1'b1, 5'd3, 64'hDEAD_BEEF);
      settle();
      check("x3_wb_ready", {63'd0, iss_ready}, 64'd1);
      check("x3_bypass", rs1, 64'hDEAD_BEEF);
      tick();
      idle();
      iss_rs1id = 5'd3;
      settle();
      check("x3_array", rs1, 64'hDEAD_BEEF);

      // x0 is hardwired
      wb(1'b1, 5'd0, 64'h1234);
      issue(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0);
      settle();
      check("x0_bypass", rs1, 64'd0);
      check("x0_ready0", {63'd0, iss_ready}, 64'd1);
      tick();
      wb(1'b0, 5'd0, 64'd0);
      settle();
      check("x0_read", rs1, 64'd0);
      check("x0_ready1", {63'd0, iss_ready}, 64'd1);
      idle();

      // WAW saturation on x7 (three outstanding max)
      issue(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         settle();
         check($sformatf("x7_fill%0d", i), {63'd0, iss_ready}, 64'd1);
         tick();
      end
      check("x7_full0", {63'd0, iss_ready}, 64'd0);
      tick();
      check("x7_full1", {63'd0, iss_ready}, 64'd0);
      iss_valid = 1'b0;
      wb(1'b1, 5'd7, 64'h77);
      settle();
      check("x7_wb_ready", {63'd0, iss_ready}, 64'd1);
      tick();
      wb(1'b0, 5'd0, 64'd0);
      iss_valid = 1'b1;
      settle();
      check("x7_cnt2_ready", {63'd0, iss_ready}, 64'd1);
      tick();
      iss_valid = 1'b0;
      settle();
      check("x7_cnt3_full", {63'd0, iss_ready}, 64'd0);
      // Drain the three outstanding x7 writes behind a consumer
      issue(1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0);
      wb(1'b1, 5'd7, 64'd1);
      settle();
      check("x7_drain2", {63'd0, iss_ready}, 64'd0);
      tick();
      wb(1'b1, 5'd7, 64'd2);
      settle();
      check("x7_drain1", {63'd0, iss_ready}, 64'd0);
      tick();
      wb(1'b1, 5'd7, 64'd3);
      settle();
      check("x7_drain0", {63'd0, iss_ready}, 64'd1);
      check("x7_drain_byp", rs1, 64'd3);
      tick();
      wb(1'b0, 5'd0, 64'd0);
      settle();
      check("x7_final", rs1, 64'd3);
      idle();

      // Cancel on x9 releases without writing
      issue(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      tick();
      idle();
      wb(1'b1, 5'd9, 64'h99);
      tick();
      wb(1'b0, 5'd0, 64'd0);
      issue(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      tick();
      issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
      settle();
      check("x9_busy", {63'd0, iss_ready}, 64'd0);
      cnl_valid = 1'b1; cnl_rdid = 5'd9;
      tick();
      cnl_valid = 1'b0; cnl_rdid = '0;
      settle();
      check("x9_cnl_ready", {63'd0, iss_ready}, 64'd1);
      check("x9_unchanged", rs2, 64'h99);
      idle();

      // Issue and retire on x4 in the same cycle
      issue(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      tick();
      wb(1'b1, 5'd4, 64'h44);
      settle();
      check("x4_fire_ready", {63'd0, iss_ready}, 64'd1);
      tick();
      wb(1'b0, 5'd0, 64'd0);
      issue(1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 5'd0, 1'b0);
      settle();
      check("x4_still_busy", {63'd0, iss_ready}, 64'd0);
      check("x4_data", rs1, 64'h44);
      wb(1'b1, 5'd4, 64'h55);
      settle();
      check("x4_cnt_one", {63'd0, iss_ready}, 64'd1);

      // Reset mid-stream overrides the write and the issue
      rst = 1'b1;
      issue(1'b1, 5'd5, 1'b1, 5'd4, 1'b1, 5'd7, 1'b1);
      tick();
      rst = 1'b0;
      idle();
      issue(1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 5'd7, 1'b1);
      settle();
      check("mrst_ready", {63'd0, iss_ready}, 64'd1);
      check("mrst_rs1", rs1, 64'd0);
      check("mrst_rs2", rs2, 64'd0);
      issue(1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 5'd9, 1'b1);
      settle();
      check("mrst_x5_ready", {63'd0, iss_ready}, 64'd1);
      check("mrst_x9", rs2, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Integer register file plus issue scoreboard.
- Sits at the far end of the write-back path: it consumes the WBU write port (rdwen/rd/rdid) and serves two read ports to the IDU.
- Tracks in-flight destination registers so the IDU issue handshake stalls on RAW and WAW hazards until the producer writes back or is squashed.

Parameters:
- CPU_WIDTH, 64, data width of each architectural register.
- REG_ADDRW, 5, register index width; 2**REG_ADDRW registers.
- CNT_WIDTH, 2, per-register in-flight counter width; at most 2**CNT_WIDTH-1 writes outstanding per register.

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_wbu_rdwen  in  1  write-back enable; already qualified by WBU valid.
- i_wbu_rdid  in  REG_ADDRW  write-back destination index.
- i_wbu_rd  in  CPU_WIDTH  write-back data.
- i_iss_valid  in  1  IDU has an instruction to issue.
- o_iss_ready  out  1  issue permitted this cycle.
- i_iss_rs1id  in  REG_ADDRW  source 1 index.
- i_iss_rs1en  in  1  source 1 is used.
- i_iss_rs2id  in  REG_ADDRW  source 2 index.
- i_iss_rs2en  in  1  source 2 is used.
- i_iss_rdid  in  REG_ADDRW  destination index.
- i_iss_rdwen  in  1  instruction writes rd.
- o_rs1  out  CPU_WIDTH  read data for rs1id.
- o_rs2  out  CPU_WIDTH  read data for rs2id.
- i_cnl_valid  in  1  a previously issued rd-writing instruction was squashed and will never write back.
- i_cnl_rdid  in  REG_ADDRW  destination index of the squashed instruction.

Behaviour:
- Reset (i_rst=1 at an edge): all registers cleared to 0 and all counters cleared to 0. Next cycle o_iss_ready=1, o_rs1=o_rs2=0.
- x0: reads always return 0. Writes to x0 are ignored. Issue and cancel with rdid=0 never touch a counter. Sources with index 0 are never busy.
- Write: when i_wbu_rdwen and rdid!=0, reg[rdid] <= i_wbu_rd at the edge.
- Read is combinational, with write bypass: if i_wbu_rdwen and i_wbu_rdid==rsXid!=0, o_rsX=i_wbu_rd in the same cycle; otherwise o_rsX=reg[rsXid].
- Retire event: i_wbu_rdwen with rdid!=0 decrements cnt[rdid] by 1.
- Cancel event: i_cnl_valid with rdid!=0 decrements cnt[rdid] by 1.
- Issue fire: iss_fire = i_iss_valid & o_iss_ready. If i_iss_rdwen and rdid!=0, cnt[rdid] increments by 1.
- Effective count: eff[r] = cnt[r] - retire_hit[r] - cancel_hit[r], where each hit is 0 or 1.
  - busy(r) = eff[r] != 0.
  - This gives same-cycle release: a source retiring this cycle is not busy and is read via the bypass.
- o_iss_ready is combinational: !(rs1en & busy(rs1id)) & !(rs2en & busy(rs2id)) & !(rdwen & rdid!=0 & eff[rdid]==max).
  - max = 2**CNT_WIDTH-1.
  - o_iss_ready does not depend on i_iss_valid.
- Simultaneous events on one register: next cnt = cnt + inc - retire - cancel. All combinations are legal.
  - inc and retire together leave cnt unchanged.
  - inc, retire and cancel together give cnt-1.
- Underflow is a protocol violation. Assertion required: a retire or cancel never targets a register whose count would go below 0.
- Retire and cancel on the same rdid with cnt==1 is also a violation and must be asserted.
- i_rst mid-operation: clears everything regardless of other inputs in that cycle; no write or increment takes effect.
- Latency:
  - read: 0 cycles.
  - write visible via register array: next cycle; via bypass: same cycle.
  - scoreboard update: next cycle.

Decomposition:
- Shared package: CPU_WIDTH and REG_ADDRW (same values as the rest of the core), CNT_WIDTH default, and a typedef for register index.
- One sub-module, rf_sb_cnt: a single per-register saturating-checked up/down counter.
  - Inputs: inc, dec_wb, dec_cnl.
  - Outputs: eff, busy, full.
  - Instantiated 2**REG_ADDRW-1 times in a generate loop; x0 has no counter.

Test Plan:
- Reset, then read rs1=5, rs2=0 -> o_rs1=0, o_rs2=0, o_iss_ready=1.
- Issue rdid=3 rdwen=1; next cycle issue with rs1id=3 rs1en=1 -> o_iss_ready=0. Two cycles later WBU writes x3=0xDEAD_BEEF; that cycle o_iss_ready=1 and o_rs1=0xDEAD_BEEF via bypass.
- Write x0=0x1234 and issue rdid=0 -> o_rs1 with rs1id=0 stays 0; a dependent on x0 issues immediately.
- With CNT_WIDTH=2, issue three writes to x7, then a fourth instruction with rdid=7 -> o_iss_ready=0 until one x7 writeback; count returns to 2.
- Issue rdid=9, then i_cnl_valid rdid=9 -> next cycle a consumer of x9 is ready; reg x9 is unchanged.
- Same cycle: issue rdid=4 fires and WBU retires an earlier x4 write -> cnt[4] unchanged (1); assert i_rst mid-stream -> all counts 0, o_iss_ready=1, all reads 0.
